// File: rtl/prog_lut_pkg.sv
// Shared types and limits for the programmable look-up table.
package prog_lut_pkg;
  localparam int unsigned N_IN_MAX = 6;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;
endpackage

// File: rtl/prog_lut_cfg.sv
// Serial table loader: shadow register, bit counter and commit detection.
module prog_lut_cfg
  import prog_lut_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic                 cfg_bit,
  output logic                 commit_c,
  output logic [2**N_IN-1:0]   commit_table_c
);
  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic             last_c;

  assign last_c = (count_q == CNT_W'(DEPTH - 1));

  // Restart wins over acceptance; the final accepted bit bypasses the shadow.
  always_comb begin
    count_d                   = count_q;
    shadow_d                  = shadow_q;
    commit_c                  = 1'b0;
    commit_table_c            = shadow_q;
    commit_table_c[DEPTH-1]   = cfg_bit;
    if (clear) begin
      count_d  = '0;
      shadow_d = '0;
    end else if (accept) begin
      shadow_d[count_q[N_IN-1:0]] = cfg_bit;
      if (last_c) begin
        commit_c = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: rtl/prog_lut.sv
// Programmable N_IN-input boolean function with a serially reloadable truth table.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int unsigned          N_IN        = 3,
  parameter logic [2**N_IN-1:0]   RESET_TABLE = (2**N_IN)'(8'b0000_0101)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  output logic            out_f
);
  localparam int unsigned DEPTH = 2 ** N_IN;

  state_e           state_q, state_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_done_q, cfg_done_d;
  logic             out_valid_q, out_valid_d;
  logic             out_f_q, out_f_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic             accept_c;
  logic             commit_c;
  logic [DEPTH-1:0] commit_table_c;

  // A bit coincident with a (re)start is never taken.
  assign accept_c = cfg_valid && (state_q == LOAD) && !cfg_start;

  prog_lut_cfg #(.N_IN(N_IN)) u_cfg (
    .clk            (clk),
    .rst            (rst),
    .clear          (cfg_start),
    .accept         (accept_c),
    .cfg_bit        (cfg_bit),
    .commit_c       (commit_c),
    .commit_table_c (commit_table_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (cfg_start) state_d = LOAD;
      LOAD: begin
        if (cfg_start)     state_d = LOAD;
        else if (commit_c) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Evaluation always reads the pre-edge table, so a commit takes effect next cycle.
  always_comb begin
    cfg_ready_d = (state_d == LOAD);
    cfg_done_d  = commit_c;
    table_d     = commit_c ? commit_table_c : table_q;
    out_valid_d = in_valid;
    out_f_d     = in_valid ? table_q[in_data] : out_f_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
      table_q     <= RESET_TABLE;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      table_q     <= table_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
endmodule

// File: tb/tb_prog_lut.sv
// Directed bench for prog_lut: a default 3-input instance and a 6-input instance.
module tb_prog_lut;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start_a, cfg_valid_a, cfg_bit_a, cfg_ready_a, cfg_done_a;
  logic       in_valid_a, out_valid_a, out_f_a;
  logic [2:0] in_data_a;
  logic       cfg_start_b, cfg_valid_b, cfg_bit_b, cfg_ready_b, cfg_done_b;
  logic       in_valid_b, out_valid_b, out_f_b;
  logic [5:0] in_data_b;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt_a = 0;

  always #5 clk = ~clk;

  prog_lut #(.N_IN(3)) dut_a (
    .clk(clk), .rst(rst), .cfg_start(cfg_start_a), .cfg_valid(cfg_valid_a),
    .cfg_bit(cfg_bit_a), .cfg_ready(cfg_ready_a), .cfg_done(cfg_done_a),
    .in_valid(in_valid_a), .in_data(in_data_a), .out_valid(out_valid_a), .out_f(out_f_a)
  );

  prog_lut #(.N_IN(6)) dut_b (
    .clk(clk), .rst(rst), .cfg_start(cfg_start_b), .cfg_valid(cfg_valid_b),
    .cfg_bit(cfg_bit_b), .cfg_ready(cfg_ready_b), .cfg_done(cfg_done_b),
    .in_valid(in_valid_b), .in_data(in_data_b), .out_valid(out_valid_b), .out_f(out_f_b)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (cfg_done_a === 1'b1) done_cnt_a++;
  endtask

  task automatic start_a();
    cfg_start_a = 1'b1;
    step();
    cfg_start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_start_a = 0; cfg_valid_a = 0; cfg_bit_a = 0; in_valid_a = 0; in_data_a = '0;
    cfg_start_b = 0; cfg_valid_b = 0; cfg_bit_b = 0; in_valid_b = 0; in_data_b = '0;
    step();
    step();
    n_cmp++; if (cfg_ready_a !== 1'b0) begin n_mis++; $display("FAIL reset_ready_a got %b exp 0", cfg_ready_a); end
    n_cmp++; if (cfg_done_a !== 1'b0) begin n_mis++; $display("FAIL reset_done_a got %b exp 0", cfg_done_a); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid_a got %b exp 0", out_valid_a); end
    n_cmp++; if (out_f_a !== 1'b0) begin n_mis++; $display("FAIL reset_out_f_a got %b exp 0", out_f_a); end
    n_cmp++; if (cfg_ready_b !== 1'b0) begin n_mis++; $display("FAIL reset_ready_b got %b exp 0", cfg_ready_b); end
    n_cmp++; if (out_valid_b !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid_b got %b exp 0", out_valid_b); end
    rst = 1'b0;
  endtask

  task automatic test_eval_reset_table();
    logic [7:0] exp_tbl;
    exp_tbl = 8'b0000_0101;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 3'(i);
      step();
      n_cmp++;
      if (out_valid_a !== 1'b1 || out_f_a !== exp_tbl[i]) begin
        n_mis++;
        $display("FAIL eval_reset code %0d got v=%b f=%b exp v=1 f=%b", i, out_valid_a, out_f_a, exp_tbl[i]);
      end
    end
    in_data_a = 3'd0;
    step();
    in_valid_a = 1'b0;
    in_data_a  = 3'd1;
    step();
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_f_a !== 1'b1) begin
      n_mis++;
      $display("FAIL eval_hold got v=%b f=%b exp v=0 f=1", out_valid_a, out_f_a);
    end
  endtask

  task automatic test_load();
    logic [7:0] tbl;
    tbl = 8'b1000_0000;
    start_a();
    n_cmp++; if (cfg_ready_a !== 1'b1) begin n_mis++; $display("FAIL load_ready got %b exp 1", cfg_ready_a); end
    for (int i = 0; i < 8; i++) begin
      cfg_valid_a = 1'b1;
      cfg_bit_a   = tbl[i];
      step();
      if (i == 6) begin
        n_cmp++;
        if (cfg_done_a !== 1'b0 || cfg_ready_a !== 1'b1) begin
          n_mis++;
          $display("FAIL load_mid got done=%b ready=%b exp done=0 ready=1", cfg_done_a, cfg_ready_a);
        end
      end
    end
    n_cmp++;
    if (cfg_done_a !== 1'b1 || cfg_ready_a !== 1'b0) begin
      n_mis++;
      $display("FAIL load_commit got done=%b ready=%b exp done=1 ready=0", cfg_done_a, cfg_ready_a);
    end
    cfg_valid_a = 1'b0;
    in_valid_a  = 1'b1;
    in_data_a   = 3'd7;
    step();
    n_cmp++;
    if (cfg_done_a !== 1'b0 || out_f_a !== 1'b1) begin
      n_mis++;
      $display("FAIL load_eval7 got done=%b f=%b exp done=0 f=1", cfg_done_a, out_f_a);
    end
    in_data_a = 3'd0;
    step();
    n_cmp++; if (out_f_a !== 1'b0) begin n_mis++; $display("FAIL load_eval0 got %b exp 0", out_f_a); end
    in_valid_a = 1'b0;
  endtask

  task automatic test_commit_edge();
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_a();
    for (int i = 0; i < 7; i++) begin
      cfg_valid_a = 1'b1;
      cfg_bit_a   = 1'b0;
      step();
    end
    in_valid_a = 1'b1;
    in_data_a  = 3'd0;
    step();
    n_cmp++;
    if (out_f_a !== 1'b1 || cfg_done_a !== 1'b1) begin
      n_mis++;
      $display("FAIL commit_edge_old got f=%b done=%b exp f=1 done=1", out_f_a, cfg_done_a);
    end
    cfg_valid_a = 1'b0;
    step();
    n_cmp++; if (out_f_a !== 1'b0) begin n_mis++; $display("FAIL commit_edge_new got %b exp 0", out_f_a); end
    in_valid_a = 1'b0;
  endtask

  task automatic test_abort();
    done_cnt_a = 0;
    start_a();
    for (int i = 0; i < 3; i++) begin
      cfg_valid_a = 1'b1; cfg_bit_a = 1'b1; step();
    end
    cfg_start_a = 1'b1; cfg_bit_a = 1'b1; step(); cfg_start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_bit_a = 1'b0; step();
    end
    cfg_start_a = 1'b1; cfg_bit_a = 1'b0; step(); cfg_start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_bit_a = 1'b1; step();
    end
    cfg_valid_a = 1'b0;
    step(); step(); step();
    n_cmp++; if (done_cnt_a != 1) begin n_mis++; $display("FAIL abort_done_count got %0d exp 1", done_cnt_a); end
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 3'(i);
      step();
      n_cmp++; if (out_f_a !== 1'b1) begin n_mis++; $display("FAIL abort_table code %0d got %b exp 1", i, out_f_a); end
    end
    in_valid_a = 1'b0;
  endtask

  task automatic test_reset_during_load();
    start_a();
    for (int i = 0; i < 5; i++) begin
      cfg_valid_a = 1'b1; cfg_bit_a = 1'b1; step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (cfg_ready_a !== 1'b0) begin n_mis++; $display("FAIL rst_load_ready got %b exp 0", cfg_ready_a); end
    done_cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      cfg_valid_a = 1'b1; cfg_bit_a = 1'b0; step();
    end
    cfg_valid_a = 1'b0;
    n_cmp++;
    if (cfg_ready_a !== 1'b0 || done_cnt_a != 0) begin
      n_mis++;
      $display("FAIL run_ignore got ready=%b done_cnt=%0d exp ready=0 done_cnt=0", cfg_ready_a, done_cnt_a);
    end
    in_valid_a = 1'b1;
    in_data_a  = 3'd2;
    step();
    n_cmp++; if (out_f_a !== 1'b1) begin n_mis++; $display("FAIL rst_table code2 got %b exp 1", out_f_a); end
    in_data_a = 3'd1;
    step();
    n_cmp++; if (out_f_a !== 1'b0) begin n_mis++; $display("FAIL rst_table code1 got %b exp 0", out_f_a); end
    in_valid_a = 1'b0;
  endtask

  task automatic test_n6_gapped_load();
    logic [63:0] tbl;
    logic [5:0]  codes [4];
    logic        exps  [4];
    tbl = 64'h8000_0000_0000_0001;
    codes[0] = 6'd0;  exps[0] = 1'b1;
    codes[1] = 6'd63; exps[1] = 1'b1;
    codes[2] = 6'd1;  exps[2] = 1'b0;
    codes[3] = 6'd2;  exps[3] = 1'b0;
    cfg_start_b = 1'b1;
    step();
    cfg_start_b = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cfg_valid_b = 1'b1;
      cfg_bit_b   = tbl[i];
      step();
      if (i == 63) begin
        n_cmp++; if (cfg_done_b !== 1'b1) begin n_mis++; $display("FAIL n6_commit got %b exp 1", cfg_done_b); end
      end else if (i == 62) begin
        n_cmp++; if (cfg_done_b !== 1'b0) begin n_mis++; $display("FAIL n6_early_done got %b exp 0", cfg_done_b); end
      end
      cfg_valid_b = 1'b0;
      cfg_bit_b   = ~tbl[i];
      step();
    end
    n_cmp++;
    if (cfg_done_b !== 1'b0 || cfg_ready_b !== 1'b0) begin
      n_mis++;
      $display("FAIL n6_after got done=%b ready=%b exp 0 0", cfg_done_b, cfg_ready_b);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid_b = 1'b1;
      in_data_b  = codes[k];
      step();
      n_cmp++;
      if (out_valid_b !== 1'b1 || out_f_b !== exps[k]) begin
        n_mis++;
        $display("FAIL n6_eval code %0d got v=%b f=%b exp v=1 f=%b", codes[k], out_valid_b, out_f_b, exps[k]);
      end
    end
    in_valid_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_eval_reset_table();
    test_load();
    test_commit_edge();
    test_abort();
    test_reset_during_load();
    test_n6_gapped_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
